buf_in_packetizer: RTL and testbench

BUF_IN_PACKETIZER -- requirements
Module: buf_in_packetizer

---
 rtl/buf_in_packetizer.sv | 170 +++++++++++++++++
 tb/tb_buf_in_packetizer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_in_packetizer.sv
// Packs an 8-bit valid/ready byte stream into the core IN buffer, then commits each packet by handshake.
// Writes land one cycle after accept; s_ready is low outside FILL. Optional idle flush: BUF_IN_FLUSH_TIMEOUT_EN.
module buf_in_packetizer #(
   parameter int MAX_PKT        = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        phy_ulpi_clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        buf_in_ready,
   output logic [8:0]  buf_in_addr,
   output logic [7:0]  buf_in_data,
   output logic        buf_in_wren,
   output logic        buf_in_commit,
   output logic [9:0]  buf_in_commit_len,
   input  logic        buf_in_commit_ack,
   output logic [15:0] stat_pkt_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      LAST_WR = 3'd2,
      COMMIT  = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        s_ready_q, s_ready_d;
   logic        wren_q, wren_d;
   logic [8:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        commit_q, commit_d;
   logic [9:0]  len_q, len_d;
   logic [15:0] stat_q, stat_d;

   logic accept;
   logic pkt_end;
   logic timeout;

   // s_ready_q is only ever high while in FILL, so it alone qualifies an accept.
   assign accept  = s_valid && s_ready_q;
   assign pkt_end = s_last || ((cnt_q + 10'd1) == MAX_LEN);

`ifdef BUF_IN_FLUSH_TIMEOUT_EN
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      timeout = 1'b0;
      if ((state_q != FILL) || accept) begin
         timer_d = '0;
      end else if (cnt_q != 10'd0) begin
         if (timer_q == TIMER_LAST) begin
            timeout = 1'b1;
            timer_d = '0;
         end else begin
            timer_d = timer_q + 16'd1;
         end
      end
   end

   always_ff @(posedge phy_ulpi_clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      commit_d = commit_q;
      len_d    = len_q;
      stat_d   = stat_q;

      unique case (state_q)
         IDLE: begin
            if (buf_in_ready) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         FILL: begin
            // An accept always beats a flush in the same cycle.
            if (accept) begin
               wren_d = 1'b1;
               addr_d = cnt_q[8:0];
               data_d = s_data;
               cnt_d  = cnt_q + 10'd1;
               if (pkt_end) begin
                  state_d = LAST_WR;
               end
            end else if (timeout) begin
               state_d  = COMMIT;
               commit_d = 1'b1;
               len_d    = cnt_q;
            end
         end
         LAST_WR: begin
            state_d  = COMMIT;
            commit_d = 1'b1;
            len_d    = cnt_q;
         end
         COMMIT: begin
            if (buf_in_commit_ack) begin
               state_d  = HOLD;
               commit_d = 1'b0;
               stat_d   = stat_q + 16'd1;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      s_ready_d = (state_d == FILL);
   end

   always_ff @(posedge phy_ulpi_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         commit_q  <= 1'b0;
         len_q     <= '0;
         stat_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         wren_q    <= wren_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         commit_q  <= commit_d;
         len_q     <= len_d;
         stat_q    <= stat_d;
      end
   end

   assign s_ready           = s_ready_q;
   assign buf_in_wren       = wren_q;
   assign buf_in_addr       = addr_q;
   assign buf_in_data       = data_q;
   assign buf_in_commit     = commit_q;
   assign buf_in_commit_len = len_q;
   assign stat_pkt_cnt      = stat_q;

endmodule

// File: tb/tb_buf_in_packetizer.sv
// Directed bench for buf_in_packetizer: inputs driven on the falling edge, outputs sampled 2 ns later.
module tb_buf_in_packetizer;

   logic        clk;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        buf_in_ready;
   logic [8:0]  buf_in_addr;
   logic [7:0]  buf_in_data;
   logic        buf_in_wren;
   logic        buf_in_commit;
   logic [9:0]  buf_in_commit_len;
   logic        buf_in_commit_ack;
   logic [15:0] stat_pkt_cnt;

   int checks = 0;
   int passes = 0;

   buf_in_packetizer #(.MAX_PKT(512), .TIMEOUT_CYCLES(8)) dut (
      .phy_ulpi_clk      (clk),
      .reset             (reset),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_last            (s_last),
      .s_ready           (s_ready),
      .buf_in_ready      (buf_in_ready),
      .buf_in_addr       (buf_in_addr),
      .buf_in_data       (buf_in_data),
      .buf_in_wren       (buf_in_wren),
      .buf_in_commit     (buf_in_commit),
      .buf_in_commit_len (buf_in_commit_len),
      .buf_in_commit_ack (buf_in_commit_ack),
      .stat_pkt_cnt      (stat_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Commit responder: acks after ack_delay cycles of buf_in_commit high.
   int ack_delay = 0;
   int ack_wait  = 0;
   always @(negedge clk) begin
      if (buf_in_commit && !buf_in_commit_ack) begin
         if (ack_wait >= ack_delay) begin
            buf_in_commit_ack = 1'b1;
            ack_wait = 0;
         end else begin
            ack_wait++;
         end
      end else begin
         buf_in_commit_ack = 1'b0;
         ack_wait = 0;
      end
   end

   // Monitor: record writes, commit lengths and handshake observations.
   logic [8:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   logic [9:0] commit_len_q[$];
   int         n_accept = 0;
   int         bad_ready = 0;
   int         commit_hi_cycles = 0;
   int         len_unstable = 0;
   logic       commit_prev = 1'b0;
   logic [9:0] len_prev = '0;

   always begin
      @(negedge clk);
      #2;
      if (buf_in_wren) begin
         wr_addr_q.push_back(buf_in_addr);
         wr_data_q.push_back(buf_in_data);
      end
      if (s_valid && s_ready) n_accept++;
      if (buf_in_commit && !commit_prev) commit_len_q.push_back(buf_in_commit_len);
      if (buf_in_commit && commit_prev && (buf_in_commit_len != len_prev)) len_unstable++;
      if (buf_in_commit && !buf_in_commit_ack) commit_hi_cycles++;
      if (s_ready && (buf_in_commit || commit_prev)) bad_ready++;
      commit_prev = buf_in_commit;
      len_prev    = buf_in_commit_len;
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      commit_len_q.delete();
      n_accept         = 0;
      bad_ready        = 0;
      commit_hi_cycles = 0;
      len_unstable     = 0;
   endtask

   task automatic push(input int n, input logic [7:0] base, input bit last_on_end);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 5000) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = base + 8'(i);
         s_last  = last_on_end && (i == n - 1);
         if (s_ready) i++;
         guard++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_stat(input logic [15:0] exp, input string name);
      int g = 0;
      while (stat_pkt_cnt !== exp && g < 3000) begin
         @(negedge clk);
         g++;
      end
      #2;
      checks++;
      if (stat_pkt_cnt !== exp) $display("FAIL %s stat_pkt_cnt: got %0d want %0d", name, stat_pkt_cnt, exp);
      else passes++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else passes++;
      checks++; if (buf_in_wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", buf_in_wren); else passes++;
      checks++; if (buf_in_commit !== 1'b0) $display("FAIL reset_commit: got %b want 0", buf_in_commit); else passes++;
      checks++; if (buf_in_addr !== 9'd0) $display("FAIL reset_addr: got %0h want 0", buf_in_addr); else passes++;
      checks++; if (buf_in_data !== 8'd0) $display("FAIL reset_data: got %0h want 0", buf_in_data); else passes++;
      checks++; if (buf_in_commit_len !== 10'd0) $display("FAIL reset_len: got %0d want 0", buf_in_commit_len); else passes++;
      checks++; if (stat_pkt_cnt !== 16'd0) $display("FAIL reset_stat: got %0d want 0", stat_pkt_cnt); else passes++;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      checks++; if (s_ready !== 1'b0) $display("FAIL idle_no_buf_ready_s_ready: got %b want 0", s_ready); else passes++;
   endtask

   task automatic test_basic();
      int lenv;
      @(negedge clk);
      buf_in_ready = 1'b1;
      clear_mon();
      push(4, 8'h11, 1'b1);
      wait_stat(16'd1, "basic");
      checks++; if (wr_addr_q.size() != 4) $display("FAIL basic_write_count: got %0d want 4", wr_addr_q.size()); else passes++;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= wr_addr_q.size() || wr_addr_q[k] !== 9'(k) || wr_data_q[k] !== 8'h11 + 8'(k))
            $display("FAIL basic_write%0d: got addr/data %0h/%0h want %0h/%0h", k,
                     (k < wr_addr_q.size()) ? wr_addr_q[k] : 9'h1ff,
                     (k < wr_data_q.size()) ? wr_data_q[k] : 8'h00, k, 8'h11 + 8'(k));
         else passes++;
      end
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (commit_len_q.size() != 1) $display("FAIL basic_commit_count: got %0d want 1", commit_len_q.size()); else passes++;
      checks++; if (lenv != 4) $display("FAIL basic_commit_len: got %0d want 4", lenv); else passes++;
   endtask

   task automatic test_max_pkt();
      int errs = 0;
      int l0;
      int l1;
      clear_mon();
      push(600, 8'h00, 1'b1);
      wait_stat(16'd3, "max_pkt");
      l0 = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      l1 = (commit_len_q.size() > 1) ? int'(commit_len_q[1]) : -1;
      checks++; if (commit_len_q.size() != 2) $display("FAIL max_commit_count: got %0d want 2", commit_len_q.size()); else passes++;
      checks++; if (l0 != 512) $display("FAIL max_first_len: got %0d want 512", l0); else passes++;
      checks++; if (l1 != 88) $display("FAIL max_second_len: got %0d want 88", l1); else passes++;
      checks++; if (wr_addr_q.size() != 600) $display("FAIL max_write_count: got %0d want 600", wr_addr_q.size()); else passes++;
      for (int k = 0; k < wr_addr_q.size() && k < 600; k++) begin
         if (wr_addr_q[k] !== 9'((k < 512) ? k : k - 512) || wr_data_q[k] !== 8'(k)) errs++;
      end
      checks++; if (errs != 0) $display("FAIL max_addr_data_seq: got %0d bad writes want 0", errs); else passes++;
      checks++; if (bad_ready != 0) $display("FAIL max_ready_in_commit_hold: got %0d cycles want 0", bad_ready); else passes++;
      checks++; if (n_accept != 600) $display("FAIL max_accepts: got %0d want 600", n_accept); else passes++;
   endtask

   task automatic test_ack_delay();
      int g = 0;
      int lenv;
      while (!s_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      ack_delay = 20;
      buf_in_ready = 1'b0;
      clear_mon();
      push(4, 8'h21, 1'b1);
      s_valid = 1'b1;
      s_data  = 8'h99;
      s_last  = 1'b0;
      wait_stat(16'd4, "ack_delay");
      @(negedge clk);
      s_valid = 1'b0;
      ack_delay = 0;
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (lenv != 4) $display("FAIL ackdly_len: got %0d want 4", lenv); else passes++;
      checks++; if (commit_hi_cycles != 20) $display("FAIL ackdly_commit_cycles: got %0d want 20", commit_hi_cycles); else passes++;
      checks++; if (len_unstable != 0) $display("FAIL ackdly_len_stable: got %0d changes want 0", len_unstable); else passes++;
      checks++; if (n_accept != 4) $display("FAIL ackdly_accepts: got %0d want 4", n_accept); else passes++;
      checks++; if (bad_ready != 0) $display("FAIL ackdly_ready_in_commit: got %0d want 0", bad_ready); else passes++;
   endtask

   task automatic test_reset_mid();
      int lenv;
      @(negedge clk);
      buf_in_ready = 1'b1;
      clear_mon();
      push(5, 8'h60, 1'b0);
      reset = 1'b1;
      #2;
      checks++; if (buf_in_wren !== 1'b0) $display("FAIL rstmid_wren: got %b want 0", buf_in_wren); else passes++;
      checks++; if (s_ready !== 1'b0) $display("FAIL rstmid_s_ready: got %b want 0", s_ready); else passes++;
      checks++; if (buf_in_addr !== 9'd0) $display("FAIL rstmid_addr: got %0h want 0", buf_in_addr); else passes++;
      checks++; if (stat_pkt_cnt !== 16'd0) $display("FAIL rstmid_stat: got %0d want 0", stat_pkt_cnt); else passes++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      buf_in_ready = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (commit_len_q.size() != 0) $display("FAIL rstmid_no_commit: got %0d commits want 0", commit_len_q.size()); else passes++;
      clear_mon();
      buf_in_ready = 1'b1;
      push(2, 8'h31, 1'b1);
      wait_stat(16'd1, "rstmid_next");
      checks++;
      if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 8'h31)
         $display("FAIL rstmid_first_write: got addr/data %0h/%0h want 0/31",
                  (wr_addr_q.size() > 0) ? wr_addr_q[0] : 9'h1ff, (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00);
      else passes++;
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (lenv != 2) $display("FAIL rstmid_len: got %0d want 2", lenv); else passes++;
   endtask

`ifdef BUF_IN_FLUSH_TIMEOUT_EN
   task automatic test_timeout();
      int idle;
      int lenv;
      clear_mon();
      push(3, 8'h41, 1'b0);
      idle = 0;
      #2;
      while (!buf_in_commit && idle < 100) begin
         idle++;
         @(negedge clk);
         #2;
      end
      checks++; if (idle != 8) $display("FAIL timeout_idle_cycles: got %0d want 8", idle); else passes++;
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (lenv != 3) $display("FAIL timeout_len: got %0d want 3", lenv); else passes++;
      wait_stat(16'd2, "timeout");

      clear_mon();
      push(3, 8'h51, 1'b0);
      repeat (7) @(negedge clk);
      checks++; if (s_ready !== 1'b1) $display("FAIL timeout_edge_ready: got %b want 1", s_ready); else passes++;
      s_valid = 1'b1;
      s_data  = 8'h54;
      @(negedge clk);
      s_valid = 1'b0;
      idle = 0;
      #2;
      while (!buf_in_commit && idle < 100) begin
         idle++;
         @(negedge clk);
         #2;
      end
      checks++; if (idle != 8) $display("FAIL timeout_extend_idle: got %0d want 8", idle); else passes++;
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (lenv != 4) $display("FAIL timeout_extend_len: got %0d want 4", lenv); else passes++;
      wait_stat(16'd3, "timeout_extend");
   endtask
`else
   task automatic test_no_timeout();
      int lenv;
      clear_mon();
      push(3, 8'h41, 1'b0);
      repeat (30) @(negedge clk);
      #2;
      checks++; if (commit_len_q.size() != 0) $display("FAIL notimeout_commit: got %0d commits want 0", commit_len_q.size()); else passes++;
      checks++; if (s_ready !== 1'b1) $display("FAIL notimeout_ready: got %b want 1", s_ready); else passes++;
      push(1, 8'h44, 1'b1);
      wait_stat(16'd2, "notimeout");
      lenv = (commit_len_q.size() > 0) ? int'(commit_len_q[0]) : -1;
      checks++; if (lenv != 4) $display("FAIL notimeout_len: got %0d want 4", lenv); else passes++;
   endtask
`endif

   initial begin
      reset        = 1'b1;
      s_data       = 8'h00;
      s_valid      = 1'b0;
      s_last       = 1'b0;
      buf_in_ready = 1'b0;
      buf_in_commit_ack = 1'b0;
      test_reset();
      test_basic();
      test_max_pkt();
      test_ack_delay();
      test_reset_mid();
`ifdef BUF_IN_FLUSH_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
